// File: rtl/hurt_pkg.sv
// Shared types and default frame counts for the hurt palette sequencer.
package hurt_pkg;

  typedef logic [11:0] rgb12_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLASH    = 2'd1,
    COOLDOWN = 2'd2
  } hurt_state_t;

  localparam int DEF_FLASH_FRAMES    = 60;
  localparam int DEF_TOGGLE_FRAMES   = 4;
  localparam int DEF_COOLDOWN_FRAMES = 30;

endpackage

// File: rtl/hurt_phase_gen.sv
// Flash pattern generator: counts flash frames and alternates hurt/normal
// phases every TOGGLE_FRAMES frames using a toggle counter and phase bit.
module hurt_phase_gen #(
  parameter int FLASH_FRAMES  = hurt_pkg::DEF_FLASH_FRAMES,
  parameter int TOGGLE_FRAMES = hurt_pkg::DEF_TOGGLE_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic advance,
  input  logic clear,
  output logic sel_next,
  output logic done
);

  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  localparam int TG_W = (TOGGLE_FRAMES > 1) ? $clog2(TOGGLE_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TG_W-1:0] tog_cnt_q, tog_cnt_d;
  logic            phase_q, phase_d;

  assign done     = (frame_cnt_q == FC_W'(FLASH_FRAMES));
  // Phase 0 covers the even groups of TOGGLE_FRAMES, which show the hurt palette.
  assign sel_next = ~phase_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    phase_d     = phase_q;
    if (clear || start) begin
      frame_cnt_d = '0;
      tog_cnt_d   = '0;
      phase_d     = 1'b0;
    end else if (advance && !done) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
      if (tog_cnt_q == TG_W'(TOGGLE_FRAMES - 1)) begin
        tog_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        tog_cnt_d = tog_cnt_q + TG_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      tog_cnt_q   <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/hurt_palette_sequencer.sv
// Per-frame normal/hurt palette selection with flash and cooldown sequencing,
// plus a one-stage registered colour mux.
module hurt_palette_sequencer
  import hurt_pkg::*;
#(
  parameter int FLASH_FRAMES    = DEF_FLASH_FRAMES,
  parameter int TOGGLE_FRAMES   = DEF_TOGGLE_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   frame_start,
  input  logic   hit,
  input  logic   clear,
  input  logic   pixel_valid,
  input  rgb12_t normal_rgb,
  input  rgb12_t hurt_rgb,
  output rgb12_t rgb_out,
  output logic   rgb_valid,
  output logic   hurt_active,
  output logic   invulnerable,
  output logic   hit_accepted
);

  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  hurt_state_t     state_q, state_d;
  logic [CD_W-1:0] cd_cnt_q, cd_cnt_d;
  logic            sel_hurt_q, sel_hurt_d;
  logic            hit_acc_q, hit_acc_d;
  rgb12_t          rgb_q, rgb_d;
  logic            rgb_valid_q;
  logic            phase_start, phase_advance, phase_sel_next, phase_done;

  hurt_phase_gen #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .TOGGLE_FRAMES(TOGGLE_FRAMES)
  ) u_phase_gen (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .start   (phase_start),
    .advance (phase_advance),
    .clear   (clear),
    .sel_next(phase_sel_next),
    .done    (phase_done)
  );

  always_comb begin
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    sel_hurt_d    = sel_hurt_q;
    hit_acc_d     = 1'b0;
    phase_start   = 1'b0;
    phase_advance = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      cd_cnt_d   = '0;
      sel_hurt_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) sel_hurt_d = 1'b0;
          if (hit) begin
            state_d     = FLASH;
            phase_start = 1'b1;
            hit_acc_d   = 1'b1;
          end
        end
        FLASH: begin
          if (frame_start) begin
            if (phase_done) begin
              state_d    = COOLDOWN;
              cd_cnt_d   = '0;
              sel_hurt_d = 1'b0;
            end else begin
              sel_hurt_d    = phase_sel_next;
              phase_advance = 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (frame_start) begin
            if (cd_cnt_q == CD_W'(COOLDOWN_FRAMES - 1)) begin
              state_d  = IDLE;
              cd_cnt_d = '0;
            end else begin
              cd_cnt_d = cd_cnt_q + CD_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // clear forces the normal palette on the very next pixel, not at the next frame.
  always_comb begin
    rgb_d = (sel_hurt_q && !clear) ? hurt_rgb : normal_rgb;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cd_cnt_q    <= '0;
      sel_hurt_q  <= 1'b0;
      hit_acc_q   <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_cnt_q    <= cd_cnt_d;
      sel_hurt_q  <= sel_hurt_d;
      hit_acc_q   <= hit_acc_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= pixel_valid;
    end
  end

  assign rgb_out      = rgb_q;
  assign rgb_valid    = rgb_valid_q;
  assign hit_accepted = hit_acc_q;
  assign hurt_active  = (state_q == FLASH);
  assign invulnerable = (state_q != IDLE);

endmodule

// File: tb/tb_hurt_palette_sequencer.sv
// Bench for hurt_palette_sequencer: frame-level reference model checked every
// cycle, plus directed scenarios with literal per-frame colour expectations.
module tb_hurt_palette_sequencer;
  import hurt_pkg::*;

  localparam int FF = 6;
  localparam int TF = 2;
  localparam int CF = 3;
  localparam rgb12_t NRM = 12'hF40;
  localparam rgb12_t HRT = 12'hA00;

  logic   Clk = 1'b0;
  logic   Reset_n = 1'b0;
  logic   frame_start = 1'b0;
  logic   hit = 1'b0;
  logic   clear = 1'b0;
  logic   pixel_valid = 1'b0;
  rgb12_t normal_rgb = NRM;
  rgb12_t hurt_rgb = HRT;
  rgb12_t rgb_out;
  logic   rgb_valid, hurt_active, invulnerable, hit_accepted;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  hurt_palette_sequencer #(
    .FLASH_FRAMES   (FF),
    .TOGGLE_FRAMES  (TF),
    .COOLDOWN_FRAMES(CF)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .hit         (hit),
    .clear       (clear),
    .pixel_valid (pixel_valid),
    .normal_rgb  (normal_rgb),
    .hurt_rgb    (hurt_rgb),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .hurt_active (hurt_active),
    .invulnerable(invulnerable),
    .hit_accepted(hit_accepted)
  );

  always #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n counts frame_starts since the accepting hit; flash spans n=0..FF,
  // cooldown the next CF frame_starts.
  int     m_n = 0;
  logic   m_active = 1'b0;
  logic   m_sel = 1'b0;
  rgb12_t e_rgb = '0;
  logic   e_valid = 1'b0, e_acc = 1'b0, e_hurt = 1'b0, e_inv = 1'b0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_n = 0; m_active = 1'b0; m_sel = 1'b0;
      e_rgb = '0; e_valid = 1'b0; e_acc = 1'b0; e_hurt = 1'b0; e_inv = 1'b0;
    end else begin
      e_rgb   = (m_sel && !clear) ? hurt_rgb : normal_rgb;
      e_valid = pixel_valid;
      e_acc   = 1'b0;
      if (clear) begin
        m_active = 1'b0; m_n = 0; m_sel = 1'b0;
      end else if (m_active) begin
        if (frame_start) begin
          m_sel = (m_n < FF) ? (((m_n / TF) % 2) == 0) : 1'b0;
          m_n++;
          if (m_n == FF + 1 + CF) m_active = 1'b0;
        end
      end else begin
        if (frame_start) m_sel = 1'b0;
        if (hit) begin
          m_active = 1'b1; m_n = 0; e_acc = 1'b1;
        end
      end
      e_hurt = m_active && (m_n <= FF);
      e_inv  = m_active;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check_output("model_rgb_out", rgb_out, e_rgb);
      check_output("model_rgb_valid", {11'b0, rgb_valid}, {11'b0, e_valid});
      check_output("model_hit_accepted", {11'b0, hit_accepted}, {11'b0, e_acc});
      check_output("model_hurt_active", {11'b0, hurt_active}, {11'b0, e_hurt});
      check_output("model_invulnerable", {11'b0, invulnerable}, {11'b0, e_inv});
    end
  end

  task automatic cycle(input logic fs, input logic h, input logic c, input logic pv);
    frame_start = fs;
    hit         = h;
    clear       = c;
    pixel_valid = pv;
    @(negedge Clk);
    frame_start = 1'b0;
    hit         = 1'b0;
    clear       = 1'b0;
  endtask

  function automatic logic rnd_pv();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic frame_check(input string name, input rgb12_t exp, input logic h_at_fs);
    cycle(1'b1, h_at_fs, 1'b0, rnd_pv());
    check_output({name, "_no_accept"}, {11'b0, hit_accepted}, 12'h000);
    cycle(1'b0, 1'b0, 1'b0, rnd_pv());
    check_output(name, rgb_out, exp);
  endtask

  rgb12_t exp_pat [10];

  initial begin
    exp_pat = '{HRT, HRT, NRM, NRM, HRT, HRT, NRM, NRM, NRM, NRM};
    @(negedge Clk);
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);
    check_output("reset_rgb_out", rgb_out, 12'h000);
    check_output("reset_rgb_valid", {11'b0, rgb_valid}, 12'h000);
    check_output("reset_invulnerable", {11'b0, invulnerable}, 12'h000);
    check_output("reset_hit_accepted", {11'b0, hit_accepted}, 12'h000);
    Reset_n = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, rnd_pv());

    // Basic flash
    cycle(1'b0, 1'b1, 1'b0, rnd_pv());
    check_output("basic_hit_accepted", {11'b0, hit_accepted}, 12'h001);
    check_output("basic_hurt_active", {11'b0, hurt_active}, 12'h001);
    for (int i = 0; i < 10; i++) begin
      frame_check("basic_frame_rgb", exp_pat[i], 1'b0);
      if (i == 8) check_output("basic_inv_before_end", {11'b0, invulnerable}, 12'h001);
    end
    check_output("basic_inv_after_end", {11'b0, invulnerable}, 12'h000);

    // Ignored hits in flash and cooldown, then retrigger right after IDLE
    cycle(1'b0, 1'b1, 1'b0, rnd_pv());
    check_output("ign_hit_accepted", {11'b0, hit_accepted}, 12'h001);
    for (int i = 0; i < 9; i++) begin
      frame_check("ign_frame_rgb", exp_pat[i], (i == 2) || (i == 8));
      if (i == 0 || i == 7) begin
        cycle(1'b0, 1'b1, 1'b0, rnd_pv());
        check_output("ign_hit_dropped", {11'b0, hit_accepted}, 12'h000);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, rnd_pv());
    cycle(1'b0, 1'b1, 1'b0, rnd_pv());
    check_output("retrig_hit_accepted", {11'b0, hit_accepted}, 12'h001);
    check_output("retrig_last_rgb", rgb_out, NRM);
    for (int i = 0; i < 10; i++) frame_check("retrig_frame_rgb", exp_pat[i], 1'b0);

    // Coincident hit and frame_start in IDLE, then clear mid-flash
    cycle(1'b1, 1'b1, 1'b0, rnd_pv());
    check_output("coinc_hit_accepted", {11'b0, hit_accepted}, 12'h001);
    cycle(1'b0, 1'b0, 1'b0, rnd_pv());
    check_output("coinc_frame_rgb", rgb_out, NRM);
    frame_check("coinc_next_frame_rgb", HRT, 1'b0);
    check_output("clear_pre_rgb", rgb_out, HRT);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_output("clear_rgb_out", rgb_out, NRM);
    check_output("clear_rgb_valid", {11'b0, rgb_valid}, 12'h001);
    check_output("clear_invulnerable", {11'b0, invulnerable}, 12'h000);
    check_output("clear_hurt_active", {11'b0, hurt_active}, 12'h000);

    // Async reset mid-cooldown
    cycle(1'b0, 1'b1, 1'b0, rnd_pv());
    for (int i = 0; i < 8; i++) frame_check("rst_seq_frame_rgb", exp_pat[i], 1'b0);
    check_output("rst_pre_inv", {11'b0, invulnerable}, 12'h001);
    pixel_valid = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check_output("async_rst_rgb_out", rgb_out, 12'h000);
    check_output("async_rst_rgb_valid", {11'b0, rgb_valid}, 12'h000);
    check_output("async_rst_invulnerable", {11'b0, invulnerable}, 12'h000);
    check_output("async_rst_hurt_active", {11'b0, hurt_active}, 12'h000);
    check_output("async_rst_hit_accepted", {11'b0, hit_accepted}, 12'h000);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, rnd_pv());
    cycle(1'b0, 1'b1, 1'b0, rnd_pv());
    check_output("post_rst_hit_accepted", {11'b0, hit_accepted}, 12'h001);
    for (int i = 0; i < 3; i++) frame_check("post_rst_frame_rgb", exp_pat[i], 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, rnd_pv());

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
